// File: rtl/trdb_stream_unpack.sv
// Trace stream unpacker: rebuilds length-prefixed trace packets from the 32-bit aligned word stream.
// Optional build macro TRDB_UNPACK_ZERO_CHECK_EN flags nonzero fill bits in the last word of a frame.

package trdb_pkg;
    parameter int unsigned PACKET_LEN        = 128;
    parameter int unsigned PACKET_HEADER_LEN = 8;
endpackage

module trdb_stream_unpack #(
    parameter int unsigned PACKET_LEN        = trdb_pkg::PACKET_LEN,
    parameter int unsigned PACKET_HEADER_LEN = trdb_pkg::PACKET_HEADER_LEN
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [31:0]                  data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [PACKET_LEN-1:0]        packet_bits_o,
    output logic [PACKET_HEADER_LEN-1:0] packet_len_o,
    output logic                         valid_o,
    input  logic                         grant_i,
    output logic                         err_o
);

    localparam int unsigned ACC_W  = PACKET_HEADER_LEN + PACKET_LEN + 32;
    localparam int unsigned FILL_W = $clog2(ACC_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DELIVER = 2'd2
    } state_e;

    // Keeps only payload bits below the decoded length.
    function automatic logic [PACKET_LEN-1:0] len_mask(input logic [PACKET_HEADER_LEN-1:0] len);
        logic [PACKET_LEN-1:0] m;
        for (int i = 0; i < int'(PACKET_LEN); i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

`ifdef TRDB_UNPACK_ZERO_CHECK_EN
    // Selects the zero-fill bits of the last word; a fully used word has none.
    function automatic logic [31:0] fill_mask(input logic [4:0] pos);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) begin
            m[i] = (pos != 5'd0) && (i >= int'(pos));
        end
        return m;
    endfunction
`endif

    state_e                       state_r, state_n;
    logic [ACC_W-1:0]             acc_r, acc_n, acc_ins_s;
    logic [FILL_W-1:0]            fill_r, fill_n, fill_add_s;
    logic [PACKET_HEADER_LEN-1:0] len_r, len_n, hdr_len_s, cur_len_s;
    logic                         ready_r, ready_n;
    logic                         valid_r, valid_n;
    logic [PACKET_LEN-1:0]        bits_r, bits_n;
    logic [PACKET_HEADER_LEN-1:0] plen_r, plen_n;
    logic                         err_r, err_n;
    logic                         accept_s, deliver_s, last_word_s;
    logic [31:0]                  frame_bits_s;

    // Next-state, accumulator update and packet output decode.
    always_comb begin
        state_n    = state_r;
        acc_n      = acc_r;
        fill_n     = fill_r;
        len_n      = len_r;
        valid_n    = valid_r;
        bits_n     = bits_r;
        plen_n     = plen_r;
        err_n      = 1'b0;
        deliver_s  = 1'b0;

        accept_s     = valid_i && (state_r != ST_DELIVER);
        hdr_len_s    = data_i[PACKET_HEADER_LEN-1:0];
        cur_len_s    = (state_r == ST_IDLE) ? hdr_len_s : len_r;
        acc_ins_s    = acc_r;
        acc_ins_s[fill_r +: 32] = data_i;
        fill_add_s   = fill_r + FILL_W'(32);
        frame_bits_s = 32'(PACKET_HEADER_LEN) + 32'(cur_len_s);
        last_word_s  = (32'(fill_add_s) >= frame_bits_s);

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (hdr_len_s == '0) begin
                        state_n = ST_IDLE;
                    end else if (32'(hdr_len_s) > PACKET_LEN) begin
                        err_n = 1'b1;
                    end else begin
                        len_n  = hdr_len_s;
                        acc_n  = acc_ins_s;
                        fill_n = fill_add_s;
                        if (last_word_s) begin
                            deliver_s = 1'b1;
                        end else begin
                            state_n = ST_COLLECT;
                        end
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (accept_s) begin
                    acc_n  = acc_ins_s;
                    fill_n = fill_add_s;
                    if (last_word_s) begin
                        deliver_s = 1'b1;
                    end else begin
                        state_n = ST_COLLECT;
                    end
                end else begin
                    state_n = ST_COLLECT;
                end
            end
            ST_DELIVER: begin
                if (grant_i) begin
                    state_n = ST_IDLE;
                    acc_n   = '0;
                    fill_n  = '0;
                    len_n   = '0;
                    valid_n = 1'b0;
                    bits_n  = '0;
                    plen_n  = '0;
                end else begin
                    state_n = ST_DELIVER;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (deliver_s) begin
            state_n = ST_DELIVER;
            valid_n = 1'b1;
            bits_n  = acc_ins_s[PACKET_HEADER_LEN +: PACKET_LEN] & len_mask(cur_len_s);
            plen_n  = cur_len_s;
`ifdef TRDB_UNPACK_ZERO_CHECK_EN
            err_n   = |(data_i & fill_mask(frame_bits_s[4:0]));
`endif
        end else begin
            valid_n = valid_n;
        end

        ready_n = (state_n != ST_DELIVER);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            acc_r   <= '0;
            fill_r  <= '0;
            len_r   <= '0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            bits_r  <= '0;
            plen_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            acc_r   <= acc_n;
            fill_r  <= fill_n;
            len_r   <= len_n;
            ready_r <= ready_n;
            valid_r <= valid_n;
            bits_r  <= bits_n;
            plen_r  <= plen_n;
            err_r   <= err_n;
        end
    end

    assign ready_o       = ready_r;
    assign valid_o       = valid_r;
    assign packet_bits_o = bits_r;
    assign packet_len_o  = plen_r;
    assign err_o         = err_r;

endmodule
